// File: rtl/alu_seq.sv
// Byte-serial 8/16/24/32-bit ADD/AND/OR/XOR sequencer driving an external
// registered 8-bit ALU; results are captured one cycle behind each issue.
module alu_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [1:0]  nbytes,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        carry_out,
  output logic        zero,
  output logic        busy,
  output logic        done,
  output logic [2:0]  alu_opcode,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_enable,
  input  logic [7:0]  alu_out,
  input  logic        alu_carry
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, CAPTURE = 2'd2} state_t;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_AND  = 2'b01;
  localparam logic [1:0] OP_OR   = 2'b10;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;
  localparam logic [2:0] ALU_ADC = 3'b111;

  state_t      state_reg, state_next;
  logic [1:0]  idx_reg, idx_next;
  logic [1:0]  op_reg, op_next;
  logic [1:0]  nbytes_reg, nbytes_next;
  logic [31:0] a_reg, a_next;
  logic [31:0] b_reg, b_next;
  logic [31:0] result_reg, result_next;
  logic        carry_reg, carry_next;
  logic        zero_reg, zero_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;

  logic [7:0]  a_byte [4];
  logic [7:0]  b_byte [4];
  logic [1:0]  cap_idx;
  logic [31:0] merged;
  logic [2:0]  opcode_sel;

  // The ALU output always belongs to the byte issued one cycle earlier.
  assign cap_idx = (state_reg == CAPTURE) ? nbytes_reg : idx_reg - 2'd1;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bytes
      localparam logic [1:0] K = gi;
      assign a_byte[gi]         = a_reg[8*gi +: 8];
      assign b_byte[gi]         = b_reg[8*gi +: 8];
      assign merged[8*gi +: 8]  = (cap_idx == K) ? alu_out : result_reg[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    opcode_sel = ALU_XOR;
    case (op_reg)
      OP_ADD:  opcode_sel = (idx_reg == 2'd0) ? ALU_ADD : ALU_ADC;
      OP_AND:  opcode_sel = ALU_AND;
      OP_OR:   opcode_sel = ALU_OR;
      default: opcode_sel = ALU_XOR;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    op_next     = op_reg;
    nbytes_next = nbytes_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    result_next = result_reg;
    carry_next  = carry_reg;
    zero_next   = zero_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;
    alu_enable  = 1'b0;
    alu_opcode  = 3'b000;
    alu_a       = 8'h00;
    alu_b       = 8'h00;
    case (state_reg)
      IDLE: begin
        if (start) begin
          op_next     = op;
          nbytes_next = nbytes;
          a_next      = a;
          b_next      = b;
          result_next = 32'h0;
          busy_next   = 1'b1;
          idx_next    = 2'd0;
          state_next  = ISSUE;
        end
      end
      ISSUE: begin
        alu_enable = 1'b1;
        alu_opcode = opcode_sel;
        alu_a      = a_byte[idx_reg];
        alu_b      = b_byte[idx_reg];
        if (idx_reg != 2'd0) result_next = merged;
        if (idx_reg == nbytes_reg) state_next = CAPTURE;
        else                       idx_next   = idx_reg + 2'd1;
      end
      CAPTURE: begin
        // idx_reg still points at the last byte, so the ALU inputs hold.
        alu_enable  = 1'b1;
        alu_opcode  = opcode_sel;
        alu_a       = a_byte[idx_reg];
        alu_b       = b_byte[idx_reg];
        result_next = merged;
        carry_next  = (op_reg == OP_ADD) ? alu_carry : 1'b0;
        zero_next   = (merged == 32'h0);
        busy_next   = 1'b0;
        done_next   = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      idx_reg    <= 2'd0;
      op_reg     <= 2'd0;
      nbytes_reg <= 2'd0;
      a_reg      <= 32'h0;
      b_reg      <= 32'h0;
      result_reg <= 32'h0;
      carry_reg  <= 1'b0;
      zero_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      op_reg     <= op_next;
      nbytes_reg <= nbytes_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      result_reg <= result_next;
      carry_reg  <= carry_next;
      zero_reg   <= zero_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

  assign result    = result_reg;
  assign carry_out = carry_reg;
  assign zero      = zero_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq with a behavioural registered 8-bit ALU.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [1:0]  nbytes;
  logic [31:0] a, b;
  logic [31:0] result;
  logic        carry_out, zero, busy, done;
  logic [2:0]  alu_opcode;
  logic [7:0]  alu_a, alu_b;
  logic        alu_enable;
  logic [7:0]  alu_out = 8'h00;
  logic        alu_carry = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] res;
    logic        cy;
    logic        z;
    int          lat;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] opc_log[$];

  always #5 clk = ~clk;

  alu_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .nbytes(nbytes),
    .a(a), .b(b), .result(result), .carry_out(carry_out), .zero(zero),
    .busy(busy), .done(done), .alu_opcode(alu_opcode), .alu_a(alu_a),
    .alu_b(alu_b), .alu_enable(alu_enable), .alu_out(alu_out),
    .alu_carry(alu_carry)
  );

  // Registered 8-bit ALU; carry persists between uses, as a real one would.
  always @(posedge clk) begin
    if (alu_enable) begin
      case (alu_opcode)
        3'b000: {alu_carry, alu_out} <= {1'b0, alu_a} + {1'b0, alu_b};
        3'b111: {alu_carry, alu_out} <= {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_carry};
        3'b100: begin alu_out <= alu_a & alu_b; alu_carry <= 1'b0; end
        3'b101: begin alu_out <= alu_a | alu_b; alu_carry <= 1'b0; end
        3'b110: begin alu_out <= alu_a ^ alu_b; alu_carry <= 1'b0; end
        default: begin alu_out <= 8'h00; alu_carry <= 1'b0; end
      endcase
    end
  end

  always @(negedge clk) if (alu_enable) opc_log.push_back(alu_opcode);

  // Whole-word reference: the operation applied to the masked operands at once.
  function automatic exp_t model(input logic [1:0] o, input logic [1:0] nb,
                                 input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    int          w;
    logic [31:0] mask;
    logic [32:0] sum;
    w    = 8 * (int'(nb) + 1);
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    sum  = {1'b0, x & mask} + {1'b0, y & mask};
    e.cy = 1'b0;
    case (o)
      2'b00: begin e.res = sum[31:0] & mask; e.cy = sum[w]; end
      2'b01: e.res = x & y & mask;
      2'b10: e.res = (x | y) & mask;
      default: e.res = (x ^ y) & mask;
    endcase
    e.z   = (e.res == 32'h0);
    e.lat = int'(nb) + 2;
    return e;
  endfunction

  task automatic drive(input logic [1:0] o, input logic [1:0] nb,
                       input logic [31:0] x, input logic [31:0] y);
    op = o; nbytes = nb; a = x; b = y;
    sb.push_back(model(o, nb, x, y));
  endtask

  // Called #1 after the start-sampling edge (or later, with cyc0 edges already spent).
  task automatic wait_done(input int cyc0, output int cyc);
    cyc = cyc0;
    while (done !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 2'b00; nbytes = 2'b00; a = 32'h0; b = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({result, carry_out, zero, busy, done, alu_enable, alu_opcode, alu_a, alu_b} !== 56'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got res=%h cy=%b z=%b busy=%b done=%b en=%b opc=%b a=%h b=%h expected all zero",
               result, carry_out, zero, busy, done, alu_enable, alu_opcode, alu_a, alu_b);
    end
    rst_n = 1'b1;
    $display("reset: outputs res=%h busy=%b done=%b en=%b", result, busy, done, alu_enable);
  endtask

  task automatic test_add16();
    exp_t e;
    int   cyc;
    drive(2'b00, 2'd1, 32'h0000_00FF, 32'h0000_0001);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL add16_busy: got %b expected 1", busy); end
    wait_done(0, cyc);
    e = sb.pop_front();
    n_checks += 4;
    if (result !== e.res)  begin n_fail++; $display("FAIL add16_result: got %h expected %h", result, e.res); end
    if (carry_out !== e.cy) begin n_fail++; $display("FAIL add16_carry: got %b expected %b", carry_out, e.cy); end
    if (zero !== e.z)      begin n_fail++; $display("FAIL add16_zero: got %b expected %b", zero, e.z); end
    if (cyc != e.lat)      begin n_fail++; $display("FAIL add16_latency: got %0d expected %0d", cyc, e.lat); end
    $display("add16: res=%h cy=%b z=%b lat=%0d", result, carry_out, zero, cyc);
  endtask

  task automatic test_add32_wrap();
    exp_t       e;
    int         cyc;
    logic [2:0] exp_opc [4];
    exp_opc[0] = 3'b000; exp_opc[1] = 3'b111; exp_opc[2] = 3'b111; exp_opc[3] = 3'b111;
    opc_log.delete();
    drive(2'b00, 2'd3, 32'hFFFF_FFFF, 32'h0000_0001);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(0, cyc);
    e = sb.pop_front();
    n_checks += 4;
    if (result !== e.res)   begin n_fail++; $display("FAIL add32_result: got %h expected %h", result, e.res); end
    if (carry_out !== e.cy) begin n_fail++; $display("FAIL add32_carry: got %b expected %b", carry_out, e.cy); end
    if (zero !== e.z)       begin n_fail++; $display("FAIL add32_zero: got %b expected %b", zero, e.z); end
    if (cyc != e.lat)       begin n_fail++; $display("FAIL add32_latency: got %0d expected %0d", cyc, e.lat); end
    n_checks++;
    if (opc_log.size() != 5) begin
      n_fail++;
      $display("FAIL add32_enable_cycles: got %0d expected 5", opc_log.size());
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (k >= opc_log.size() || opc_log[k] !== exp_opc[k]) begin
        n_fail++;
        $display("FAIL add32_opcode%0d: got %b expected %b", k,
                 (k < opc_log.size()) ? opc_log[k] : 3'bxxx, exp_opc[k]);
      end
    end
    $display("add32: res=%h cy=%b z=%b lat=%0d opcodes=%0d", result, carry_out, zero, cyc, opc_log.size());
  endtask

  task automatic test_logic();
    exp_t e;
    int   cyc;
    drive(2'b11, 2'd0, 32'h0000_00A5, 32'h0000_00A5);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(0, cyc);
    e = sb.pop_front();
    n_checks += 4;
    if (result !== e.res)   begin n_fail++; $display("FAIL xor8_result: got %h expected %h", result, e.res); end
    if (carry_out !== e.cy) begin n_fail++; $display("FAIL xor8_carry: got %b expected %b", carry_out, e.cy); end
    if (zero !== e.z)       begin n_fail++; $display("FAIL xor8_zero: got %b expected %b", zero, e.z); end
    if (cyc != e.lat)       begin n_fail++; $display("FAIL xor8_latency: got %0d expected %0d", cyc, e.lat); end
    $display("xor8: res=%h cy=%b z=%b lat=%0d", result, carry_out, zero, cyc);

    drive(2'b01, 2'd2, 32'h00F0_F0F0, 32'hFF0F_F00F);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(0, cyc);
    e = sb.pop_front();
    n_checks += 3;
    if (result !== e.res) begin n_fail++; $display("FAIL and24_result: got %h expected %h", result, e.res); end
    if (zero !== e.z)     begin n_fail++; $display("FAIL and24_zero: got %b expected %b", zero, e.z); end
    if (cyc != e.lat)     begin n_fail++; $display("FAIL and24_latency: got %0d expected %0d", cyc, e.lat); end
    $display("and24: res=%h z=%b lat=%0d", result, zero, cyc);
  endtask

  task automatic test_busy_ignore();
    exp_t e;
    int   cyc;
    int   extra_done;
    drive(2'b00, 2'd1, 32'h0000_00FF, 32'h0000_0001);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; op = 2'b11; nbytes = 2'd3; a = 32'h1234_5678; b = 32'h0F0F_0F0F;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_flag: got %b expected 1", busy); end
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(2, cyc);
    e = sb.pop_front();
    n_checks += 3;
    if (result !== e.res)   begin n_fail++; $display("FAIL busy_result: got %h expected %h", result, e.res); end
    if (carry_out !== e.cy) begin n_fail++; $display("FAIL busy_carry: got %b expected %b", carry_out, e.cy); end
    if (cyc != e.lat)       begin n_fail++; $display("FAIL busy_latency: got %0d expected %0d", cyc, e.lat); end
    extra_done = 0;
    repeat (7) begin
      @(posedge clk); #1;
      if (done === 1'b1) extra_done++;
    end
    n_checks += 2;
    if (extra_done != 0) begin n_fail++; $display("FAIL busy_extra_done: got %0d pulses expected 0", extra_done); end
    if (result !== e.res) begin n_fail++; $display("FAIL busy_hold: got %h expected %h", result, e.res); end
    $display("busy_ignore: res=%h extra_done=%0d", result, extra_done);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   cyc;
    drive(2'b00, 2'd0, 32'h0000_007F, 32'h0000_0081);
    start = 1'b1;
    @(posedge clk); #1;
    drive(2'b10, 2'd1, 32'h0000_1200, 32'h0000_0034);
    wait_done(0, cyc);
    e = sb.pop_front();
    n_checks += 3;
    if (result !== e.res)   begin n_fail++; $display("FAIL b2b_first_result: got %h expected %h", result, e.res); end
    if (carry_out !== e.cy) begin n_fail++; $display("FAIL b2b_first_carry: got %b expected %b", carry_out, e.cy); end
    if (cyc != e.lat)       begin n_fail++; $display("FAIL b2b_first_latency: got %0d expected %0d", cyc, e.lat); end
    $display("b2b first: res=%h cy=%b lat=%0d", result, carry_out, cyc);
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_no_gap: got busy=%b done=%b expected busy=1 done=0", busy, done);
    end
    wait_done(0, cyc);
    e = sb.pop_front();
    n_checks += 3;
    if (result !== e.res)   begin n_fail++; $display("FAIL b2b_second_result: got %h expected %h", result, e.res); end
    if (carry_out !== e.cy) begin n_fail++; $display("FAIL b2b_second_carry: got %b expected %b", carry_out, e.cy); end
    if (cyc != e.lat)       begin n_fail++; $display("FAIL b2b_second_latency: got %0d expected %0d", cyc, e.lat); end
    $display("b2b second: res=%h cy=%b lat=%0d", result, carry_out, cyc);
  endtask

  task automatic test_reset_abort();
    exp_t e;
    int   cyc;
    int   done_seen;
    op = 2'b00; nbytes = 2'd3; a = 32'h0102_03FF; b = 32'h0000_0001;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({result, carry_out, zero, busy, done, alu_enable, alu_opcode, alu_a, alu_b} !== 56'h0) begin
      n_fail++;
      $display("FAIL abort_outputs: got res=%h cy=%b z=%b busy=%b done=%b en=%b opc=%b a=%h b=%h expected all zero",
               result, carry_out, zero, busy, done, alu_enable, alu_opcode, alu_a, alu_b);
    end
    done_seen = 0;
    @(posedge clk); #1;
    if (done === 1'b1) done_seen++;
    rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_seen++;
    end
    n_checks += 2;
    if (done_seen != 0) begin n_fail++; $display("FAIL abort_done: got %0d pulses expected 0", done_seen); end
    if (result !== 32'h0) begin n_fail++; $display("FAIL abort_partial: got %h expected 00000000", result); end
    $display("abort: res=%h done_pulses=%0d", result, done_seen);

    drive(2'b00, 2'd2, 32'h0080_FF80, 32'h0080_0180);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(0, cyc);
    e = sb.pop_front();
    n_checks += 3;
    if (result !== e.res)   begin n_fail++; $display("FAIL post_abort_result: got %h expected %h", result, e.res); end
    if (carry_out !== e.cy) begin n_fail++; $display("FAIL post_abort_carry: got %b expected %b", carry_out, e.cy); end
    if (cyc != e.lat)       begin n_fail++; $display("FAIL post_abort_latency: got %0d expected %0d", cyc, e.lat); end
    $display("post_abort add24: res=%h cy=%b lat=%0d", result, carry_out, cyc);
  endtask

  initial begin
    test_reset();
    test_add16();
    test_add32_wrap();
    test_logic();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
